// File: rtl/inst_fetch_queue.sv
// -----------------------------------------------------------------------------
// inst_fetch_queue
// Instruction queue between the IF1 stage register (writer) and decode
// (reader). Each entry is one aligned 8-byte fetch packet holding one or two
// instructions plus PC, branch prediction and exception information. Up to two
// in-order instructions are presented to decode per cycle; decode accepts
// 0, 1 or 2 of them.
//
// Ports
//   clk, rstn            clock, asynchronous active-low reset
//   flush                synchronous clear of all entries (beats push/pop)
//   in_valid / in_ready  writer handshake
//   in_*                 packet fields (in_pc[2] set = one-instruction packet)
//   space_ok             free entries >= SPACE_TH
//   nearly_full          exactly one free entry
//   id_accept            number of presented slots decode consumes
//   out_valid0/1 ...     slot 0 / slot 1 instruction view of the head packet
//   out_pc_next, out_badv, out_exception   head packet fields
// -----------------------------------------------------------------------------
`ifndef INST_NOP
`define INST_NOP 32'h0340_0000
`endif

module inst_fetch_queue #(
  parameter int DEPTH     = 8,
  parameter int LOG_DEPTH = 3,
  parameter int SPACE_TH  = 3
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_pc_next,
  input  logic        in_pc_taken,
  input  logic [31:0] in_inst0,
  input  logic [31:0] in_inst1,
  input  logic [31:0] in_badv,
  input  logic [6:0]  in_exception,
  input  logic [1:0]  in_excp_flag,
  output logic        space_ok,
  output logic        nearly_full,
  input  logic [1:0]  id_accept,
  output logic        out_valid0,
  output logic        out_valid1,
  output logic [31:0] out_pc0,
  output logic [31:0] out_pc1,
  output logic [31:0] out_inst0,
  output logic [31:0] out_inst1,
  output logic        out_taken0,
  output logic        out_taken1,
  output logic [31:0] out_pc_next,
  output logic [31:0] out_badv,
  output logic [6:0]  out_exception,
  output logic        out_excp0,
  output logic        out_excp1
);

  localparam logic [LOG_DEPTH:0] FULL_CNT  = (LOG_DEPTH+1)'(DEPTH);
  localparam logic [LOG_DEPTH:0] NEAR_CNT  = (LOG_DEPTH+1)'(DEPTH - 1);
  localparam logic [LOG_DEPTH:0] SPACE_CNT = (LOG_DEPTH+1)'(SPACE_TH);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic        taken;
    logic [31:0] inst0;
    logic [31:0] inst1;
    logic [31:0] badv;
    logic [6:0]  exception;
    logic [1:0]  excp_flag;
  } entry_t;

  entry_t               mem [DEPTH];
  logic [LOG_DEPTH-1:0] wr_ptr, rd_ptr;
  logic [LOG_DEPTH:0]   count;
  logic                 off;

  entry_t     head;
  logic       single;      // head packet carries one instruction
  logic       rem_two;     // two instructions of the head still pending
  logic [1:0] n_valid;
  logic [1:0] acc_eff;
  logic       push, pop, advance;

  // No full-bypass: in_ready depends only on the registered count.
  assign in_ready    = (count != FULL_CNT);
  assign space_ok    = (FULL_CNT - count) >= SPACE_CNT;
  assign nearly_full = (count == NEAR_CNT);

  assign head    = mem[rd_ptr];
  assign single  = head.pc[2];
  assign rem_two = !single && !off;

  always_comb begin
    out_valid0    = 1'b0;
    out_valid1    = 1'b0;
    out_pc0       = '0;
    out_pc1       = '0;
    out_inst0     = `INST_NOP;
    out_inst1     = `INST_NOP;
    out_taken0    = 1'b0;
    out_taken1    = 1'b0;
    out_excp0     = 1'b0;
    out_excp1     = 1'b0;
    out_pc_next   = '0;
    out_badv      = '0;
    out_exception = '0;
    if (count != '0) begin
      out_valid0    = 1'b1;
      out_pc0       = head.pc + {29'd0, off, 2'b00};
      out_inst0     = off ? head.inst1 : head.inst0;
      out_excp0     = head.excp_flag[off];
      out_taken0    = head.taken && !rem_two;
      out_pc_next   = head.pc_next;
      out_badv      = head.badv;
      out_exception = head.exception;
      // An exception on the first instruction cuts the packet there.
      if (rem_two && !head.excp_flag[0]) begin
        out_valid1 = 1'b1;
        out_pc1    = head.pc + 32'd4;
        out_inst1  = head.inst1;
        out_excp1  = head.excp_flag[1];
        out_taken1 = head.taken;
      end
    end
  end

  // Clamp decode's accept to what is actually presented.
  assign n_valid = {1'b0, out_valid0} + {1'b0, out_valid1};
  assign acc_eff = (id_accept > n_valid) ? n_valid : id_accept;

  assign push    = in_valid && in_ready && !flush;
  assign pop     = (acc_eff != 2'd0) && ((acc_eff >= n_valid) || out_excp0) && !flush;
  assign advance = (acc_eff != 2'd0) && !pop && !flush;

  // NOTE: packet storage has no reset; validity comes solely from count, so
  // stale contents are never observable and the array maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{pc: in_pc, pc_next: in_pc_next, taken: in_pc_taken,
                       inst0: in_inst0, inst1: in_inst1, badv: in_badv,
                       exception: in_exception, excp_flag: in_excp_flag};
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      off    <= 1'b0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      off    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + LOG_DEPTH'(1);
      if (pop) begin
        rd_ptr <= rd_ptr + LOG_DEPTH'(1);
        off    <= 1'b0;
      end else if (advance) begin
        off    <= 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch_queue.sv
`ifndef INST_NOP
`define INST_NOP 32'h0340_0000
`endif

module tb_inst_fetch_queue;

  localparam int DEPTH    = 8;
  localparam int SPACE_TH = 3;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic        taken;
    logic [31:0] inst0;
    logic [31:0] inst1;
    logic [31:0] badv;
    logic [6:0]  exception;
    logic [1:0]  flag;
  } pkt_t;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_pc = '0, in_pc_next = '0, in_inst0 = '0, in_inst1 = '0, in_badv = '0;
  logic        in_pc_taken = 1'b0;
  logic [6:0]  in_exception = '0;
  logic [1:0]  in_excp_flag = '0;
  logic        space_ok, nearly_full;
  logic [1:0]  id_accept = '0;
  logic        out_valid0, out_valid1, out_taken0, out_taken1, out_excp0, out_excp1;
  logic [31:0] out_pc0, out_pc1, out_inst0, out_inst1, out_pc_next, out_badv;
  logic [6:0]  out_exception;

  int n_checks = 0;
  int n_fail   = 0;

  pkt_t model_q[$];
  int   model_off = 0;

  inst_fetch_queue #(.DEPTH(DEPTH), .LOG_DEPTH(3), .SPACE_TH(SPACE_TH)) dut (
    .clk(clk), .rstn(rstn), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_pc_next(in_pc_next), .in_pc_taken(in_pc_taken),
    .in_inst0(in_inst0), .in_inst1(in_inst1), .in_badv(in_badv),
    .in_exception(in_exception), .in_excp_flag(in_excp_flag),
    .space_ok(space_ok), .nearly_full(nearly_full), .id_accept(id_accept),
    .out_valid0(out_valid0), .out_valid1(out_valid1),
    .out_pc0(out_pc0), .out_pc1(out_pc1),
    .out_inst0(out_inst0), .out_inst1(out_inst1),
    .out_taken0(out_taken0), .out_taken1(out_taken1),
    .out_pc_next(out_pc_next), .out_badv(out_badv), .out_exception(out_exception),
    .out_excp0(out_excp0), .out_excp1(out_excp1)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Expected decode view derived from the queue contents and the head offset.
  task automatic compare_all();
    int   cnt, n, rem;
    logic v0, v1;
    pkt_t p;
    cnt = model_q.size();
    check("in_ready", in_ready, cnt != DEPTH);
    check("space_ok", space_ok, (DEPTH - cnt) >= SPACE_TH);
    check("nearly_full", nearly_full, cnt == DEPTH - 1);
    if (cnt == 0) begin
      check("valid0", out_valid0, 0);
      check("valid1", out_valid1, 0);
      check("pc0", out_pc0, 0);
      check("pc1", out_pc1, 0);
      check("inst0", out_inst0, `INST_NOP);
      check("inst1", out_inst1, `INST_NOP);
      check("side", {out_taken0, out_taken1, out_excp0, out_excp1}, 0);
      check("head", {out_pc_next, out_exception}, 0);
      check("badv", out_badv, 0);
      return;
    end
    p   = model_q[0];
    n   = p.pc[2] ? 1 : 2;
    rem = n - model_off;
    v0  = 1'b1;
    v1  = (rem == 2) && !p.flag[0];
    check("valid0", out_valid0, v0);
    check("valid1", out_valid1, v1);
    check("pc0", out_pc0, p.pc + 32'(4 * model_off));
    check("inst0", out_inst0, (model_off == 1) ? p.inst1 : p.inst0);
    check("excp0", out_excp0, p.flag[model_off]);
    check("taken0", out_taken0, p.taken && rem == 1);
    check("pc1", out_pc1, v1 ? p.pc + 32'd4 : 32'd0);
    check("inst1", out_inst1, v1 ? p.inst1 : `INST_NOP);
    check("excp1", out_excp1, v1 ? p.flag[1] : 1'b0);
    check("taken1", out_taken1, v1 ? p.taken : 1'b0);
    check("pc_next", out_pc_next, p.pc_next);
    check("badv", out_badv, p.badv);
    check("exception", out_exception, p.exception);
  endtask

  // Model update for one clock edge, computed from the pre-edge state.
  task automatic model_step(input bit v, input pkt_t p, input int acc, input bit fl);
    int   nv, a, n, rem;
    bit   do_push, excp0;
    if (fl) begin
      model_q.delete();
      model_off = 0;
      return;
    end
    do_push = v && (model_q.size() < DEPTH);
    if (model_q.size() != 0) begin
      n     = model_q[0].pc[2] ? 1 : 2;
      rem   = n - model_off;
      excp0 = model_q[0].flag[model_off];
      nv    = 1 + (((rem == 2) && !model_q[0].flag[0]) ? 1 : 0);
      a     = (acc < nv) ? acc : nv;
      if (a != 0) begin
        if (a >= nv || excp0) begin
          void'(model_q.pop_front());
          model_off = 0;
        end else begin
          model_off = 1;
        end
      end
    end
    if (do_push) model_q.push_back(p);
  endtask

  task automatic step(input bit v, input pkt_t p, input int acc, input bit fl);
    in_valid     = v;
    in_pc        = p.pc;
    in_pc_next   = p.pc_next;
    in_pc_taken  = p.taken;
    in_inst0     = p.inst0;
    in_inst1     = p.inst1;
    in_badv      = p.badv;
    in_exception = p.exception;
    in_excp_flag = p.flag;
    id_accept    = 2'(acc);
    flush        = fl;
    model_step(v, p, acc, fl);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  function automatic pkt_t mk(input logic [31:0] pc, input logic [31:0] i0,
                              input logic [31:0] i1, input logic tk, input logic [1:0] fl);
    pkt_t p;
    p.pc        = pc;
    p.pc_next   = pc + 32'd8;
    p.taken     = tk;
    p.inst0     = i0;
    p.inst1     = pc[2] ? `INST_NOP : i1;
    p.badv      = fl != 0 ? pc : 32'd0;
    p.exception = fl != 0 ? 7'h08 : 7'h00;
    p.flag      = fl;
    return p;
  endfunction

  function automatic pkt_t rnd_pkt();
    logic [31:0] pc;
    logic [1:0]  fl;
    pc = {$urandom(), 3'b000} | ((32'($urandom_range(0, 1))) << 2);
    fl = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
    if (pc[2]) fl[1] = 1'b0;
    return mk(pc, $urandom(), $urandom(), 1'($urandom_range(0, 1)), fl);
  endfunction

  pkt_t idle;

  initial begin
    idle = mk(32'd0, 32'd0, 32'd0, 1'b0, 2'b00);
    #12 rstn = 1'b1;
    @(posedge clk);
    #1;
    compare_all();
    check("rst_in_ready", in_ready, 1);
    check("rst_inst0", out_inst0, `INST_NOP);

    // Two-instruction packet consumed in one go.
    step(1, mk(32'h1c00_0000, 32'hA, 32'hB, 1'b0, 2'b00), 0, 0);
    check("tp1_pc1", out_pc1, 32'h1c00_0004);
    check("tp1_valid1", out_valid1, 1);
    step(0, idle, 2, 0);
    check("tp1_empty", out_valid0, 0);

    // One-instruction packet with taken prediction.
    step(1, mk(32'h1c00_0004, 32'hC, 32'h0, 1'b1, 2'b00), 0, 0);
    check("tp2_pc0", out_pc0, 32'h1c00_0004);
    check("tp2_taken0", out_taken0, 1);
    check("tp2_valid1", out_valid1, 0);
    step(0, idle, 1, 0);

    // Split consumption of a two-instruction packet.
    step(1, mk(32'h1c00_0010, 32'h11, 32'h22, 1'b1, 2'b00), 1, 0);
    step(0, idle, 1, 0);
    check("tp3_pc0", out_pc0, 32'h1c00_0014);
    check("tp3_inst0", out_inst0, 32'h22);
    check("tp3_taken0", out_taken0, 1);
    step(0, idle, 1, 0);
    check("tp3_empty", out_valid0, 0);

    // Exception on the first instruction cuts the packet.
    step(1, mk(32'h1c00_0020, 32'h33, 32'h44, 1'b0, 2'b01), 0, 0);
    check("tp4_excp0", out_excp0, 1);
    check("tp4_valid1", out_valid1, 0);
    step(0, idle, 2, 0);
    check("tp4_empty", out_valid0, 0);

    // Fill to full, then push+pop while full.
    for (int i = 0; i < DEPTH; i++) begin
      step(1, mk(32'h1c00_1000 + 32'(8 * i), $urandom(), $urandom(), 1'b0, 2'b00), 0, 0);
      if (i == 5) check("fill_space_ok6", space_ok, 0);
      if (i == 6) check("fill_nearly7", nearly_full, 1);
    end
    check("fill_full", in_ready, 0);
    step(1, rnd_pkt(), 2, 0);
    check("full_pop_only", nearly_full, 1);
    for (int i = 0; i < 4; i++) step(0, idle, 2, 0);
    step(1, mk(32'h1c00_2000, 32'h55, 32'h66, 1'b0, 2'b00), 2, 0);
    check("cnt3_space", space_ok, 1);
    for (int i = 0; i < 10; i++) step(1, rnd_pkt(), 2, 0);

    // Flush with concurrent push at count 5.
    while (model_q.size() < 5) step(1, rnd_pkt(), 0, 0);
    while (model_q.size() > 5) step(0, idle, 2, 0);
    step(1, rnd_pkt(), 0, 1);
    check("flush_valid0", out_valid0, 0);
    check("flush_ready", in_ready, 1);

    // Random traffic, including occasional flushes and clamped accepts.
    for (int i = 0; i < 1500; i++) begin
      step(1'($urandom_range(0, 2) != 0), rnd_pkt(), $urandom_range(0, 3),
           1'($urandom_range(0, 60) == 0));
    end

    // Asynchronous reset mid-stream.
    while (model_q.size() < 4) step(1, rnd_pkt(), 0, 0);
    in_valid = 1'b0;
    id_accept = 2'd0;
    #2 rstn = 1'b0;
    #1;
    model_q.delete();
    model_off = 0;
    compare_all();
    check("arst_valid0", out_valid0, 0);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    compare_all();
    for (int i = 0; i < 50; i++) step(1'($urandom_range(0, 1)), rnd_pkt(), $urandom_range(0, 3), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/inst_fetch_queue.md
Name: inst_fetch_queue

Overview:
- Instruction queue between the IF1 stage register (writer) and the decode stage (reader).
- Stores fetch packets: one aligned 8-byte fetch, 1 or 2 instructions plus PC, prediction and exception info.
- Presents up to two in-order instructions per cycle to decode, which may accept 0, 1 or 2 of them.
- Drives the writer-side flow-control signals (in_ready, space_ok, nearly_full) that IF1 uses to throttle fetch.

Parameters:
DEPTH, 8, number of packet entries (power of two)
LOG_DEPTH, 3, log2(DEPTH)
SPACE_TH, 3, minimum free entries for space_ok to be asserted

Ports:
clk  in  1  clock
rstn  in  1  reset, asynchronous, active-low
flush  in  1  synchronous clear of all entries
in_valid  in  1  writer has a packet (IF1 fifo_readygo)
in_ready  out  1  queue accepts a packet this cycle (IF1 fifo_allowin)
in_pc  in  32  packet PC; bit 2 set means one-instruction packet
in_pc_next  in  32  predicted next fetch PC
in_pc_taken  in  1  prediction taken, belongs to the last instruction of the packet
in_inst0  in  32  first instruction
in_inst1  in  32  second instruction (`INST_NOP if in_pc[2])
in_badv  in  32  exception bad address
in_exception  in  7  exception code
in_excp_flag  in  2  [0] exception on first instruction, [1] exception on second
space_ok  out  1  free entries >= SPACE_TH
nearly_full  out  1  exactly one free entry
id_accept  in  2  decode consumes 0/1/2 presented slots this cycle
out_valid0 / out_valid1  out  1 each  slot valid
out_pc0 / out_pc1  out  32 each  slot PC
out_inst0 / out_inst1  out  32 each  slot instruction
out_taken0 / out_taken1  out  1 each  prediction taken attached to slot
out_pc_next  out  32  head packet predicted next PC
out_badv  out  32  head packet badv
out_exception  out  7  head packet exception code
out_excp0 / out_excp1  out  1 each  slot carries exception

Behaviour:
- Storage: circular buffer of DEPTH entries, each holding all in_* packet fields.
- State registers: wr_ptr and rd_ptr (LOG_DEPTH bits, wrap modulo DEPTH), count (LOG_DEPTH+1 bits), head offset bit off.
- Reset (async) or flush (sync, priority over push and pop): pointers=0, count=0, off=0. The push in a flush cycle is dropped.
- Post-reset outputs: in_ready=1, space_ok=1, nearly_full=0, all out_valid*=0, out data fields=0, out_inst*=`INST_NOP.
- Push: in_valid && in_ready. Entry written at wr_ptr, wr_ptr+1, count+1.
- in_ready = (count != DEPTH). No full-bypass: a pop while full does not enable a push in the same cycle.
- space_ok = (DEPTH - count) >= SPACE_TH, from the registered count.
- nearly_full = (count == DEPTH-1), from the registered count.
- Head packet instruction count: n = in_pc[2] ? 1 : 2, stored per entry.
- Remaining instructions: rem = n - off.
- Slot 0 (combinational from head, valid when count != 0):
  - out_pc0 = pc + 4*off.
  - out_inst0 = off ? inst1 : inst0.
  - out_excp0 = excp_flag[off] (for n=1, flag[0]).
  - out_taken0 = pc_taken && rem == 1.
- Slot 1:
  - out_valid1 = out_valid0 && rem == 2 && !excp_flag[0].
  - out_pc1 = pc + 4; out_inst1 = inst1; out_excp1 = excp_flag[1]; out_taken1 = pc_taken.
- Invalid slots drive data 0 and inst `INST_NOP.
- Consumption: effective accept a = min(id_accept, number of valid slots).
  - a == 0: no change.
  - a >= valid-slot count, or slot0 carries an exception and a >= 1: pop the head (rd_ptr+1, count-1, off=0). The remaining instruction of a packet cut by an exception is discarded.
  - Otherwise (a == 1 with rem == 2): off=1, head stays.
- Push and pop in the same cycle: count unchanged, both pointers advance.
- Latency: a pushed packet is visible on outputs the cycle after the push. No combinational in-to-out path.
- id_accept must not exceed the number of valid slots. Excess is clamped, never underflows count.

Test Plan:
- Reset, then push in_pc=0x1c000000 with inst0=0xA, inst1=0xB → next cycle out_valid0=1, out_pc0=0x1c000000, out_valid1=1, out_pc1=0x1c000004; id_accept=2 → queue empty, out_valid0=0.
- Push in_pc=0x1c000004 (pc[2]=1), inst0=0xC, pc_taken=1 → only slot0 valid, out_pc0=0x1c000004, out_taken0=1, out_valid1=0.
- Two-instruction packet, id_accept=1 → next cycle off=1, out_pc0=pc+4, out_inst0=inst1, out_taken0=pc_taken, out_valid1=0; id_accept=1 → pop.
- in_excp_flag=2'b01 on a 2-instruction packet → out_valid1=0, out_excp0=1; id_accept=1 → whole packet popped.
- Push 8 packets with no accepts:
  - space_ok deasserts when count=6.
  - nearly_full=1 at count=7.
  - in_ready=0 at count=8.
  - Simultaneous in_valid and id_accept while full → only the pop occurs, count=7.
  - Push and pop together at count=3 → count stays 3.
  - Pointer wrap from 7→0 preserves order.
- flush at count=5 with a concurrent push → next cycle count=0, all out_valid=0, in_ready=1. Assert rstn low mid-stream → outputs return to reset values immediately.
